// File: rtl/tdm_demux4_pkg.sv
// Shared constants and the FSM state type for the 4-channel TDM demultiplexer.
package tdm_pkg;
    localparam int NCH      = 4;
    localparam int SLOT_W   = 2;
    localparam int ERRCNT_W = 8;

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_e;
endpackage

// File: rtl/tdm_demux4.sv
// Rebuilds 4 parallel channels from a frame_sync-delimited TDM sample stream.
// Optional saturating sync-error counter when TDM_DEMUX_ERRCNT_EN is defined.
module tdm_demux4
    import tdm_pkg::*;
#(
    parameter int DATA_W = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_W-1:0]     din,
    input  logic                  din_valid,
    input  logic                  frame_sync,
    output logic [NCH*DATA_W-1:0] dout,
    output logic                  frame_valid,
    output logic                  locked,
    output logic                  sync_err,
    output logic [SLOT_W-1:0]     slot
`ifdef TDM_DEMUX_ERRCNT_EN
    ,
    output logic [ERRCNT_W-1:0]   err_cnt
`endif
);

    state_e                  state_q, state_d;
    logic [SLOT_W-1:0]       slot_q, slot_d;
    logic [DATA_W-1:0]       shadow_q [NCH-1];
    logic [DATA_W-1:0]       shadow_d [NCH-1];
    logic [NCH*DATA_W-1:0]   dout_q, dout_d;
    logic                    frame_valid_q, frame_valid_d;
    logic                    sync_err_q, sync_err_d;

    always_comb begin
        state_d       = state_q;
        slot_d        = slot_q;
        shadow_d      = shadow_q;
        dout_d        = dout_q;
        frame_valid_d = 1'b0;
        sync_err_d    = 1'b0;

        if (din_valid) begin
            if (state_q == HUNT) begin
                if (frame_sync) begin
                    shadow_d[0] = din;
                    slot_d      = SLOT_W'(1);
                    state_d     = LOCKED;
                end
            end else if (frame_sync) begin
                // A sync anywhere but slot 0 restarts the frame on this sample.
                sync_err_d  = (slot_q != '0);
                shadow_d[0] = din;
                slot_d      = SLOT_W'(1);
            end else if (slot_q == '0) begin
                sync_err_d = 1'b1;
                state_d    = HUNT;
            end else if (slot_q == SLOT_W'(NCH-1)) begin
                dout_d        = {din, shadow_q[2], shadow_q[1], shadow_q[0]};
                frame_valid_d = 1'b1;
                slot_d        = '0;
            end else begin
                for (int i = 1; i < NCH-1; i++) begin
                    if (slot_q == SLOT_W'(i)) begin
                        shadow_d[i] = din;
                    end
                end
                slot_d = slot_q + SLOT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= HUNT;
            slot_q        <= '0;
            for (int i = 0; i < NCH-1; i++) begin
                shadow_q[i] <= '0;
            end
            dout_q        <= '0;
            frame_valid_q <= 1'b0;
            sync_err_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            slot_q        <= slot_d;
            shadow_q      <= shadow_d;
            dout_q        <= dout_d;
            frame_valid_q <= frame_valid_d;
            sync_err_q    <= sync_err_d;
        end
    end

    assign dout        = dout_q;
    assign frame_valid = frame_valid_q;
    assign sync_err    = sync_err_q;
    assign slot        = slot_q;
    assign locked      = (state_q == LOCKED);

`ifdef TDM_DEMUX_ERRCNT_EN
    logic [ERRCNT_W-1:0] err_cnt_q, err_cnt_d;

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (sync_err_d && (err_cnt_q != '1)) begin
            err_cnt_d = err_cnt_q + ERRCNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_tdm_demux4.sv
// Table-driven bench for tdm_demux4 with a frame scoreboard on frame_valid.
module tb_tdm_demux4;
    import tdm_pkg::*;

    localparam int DW = 1;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic [DW-1:0]       din = '0;
    logic                din_valid = 1'b0;
    logic                frame_sync = 1'b0;
    logic [NCH*DW-1:0]   dout;
    logic                frame_valid;
    logic                locked;
    logic                sync_err;
    logic [SLOT_W-1:0]   slot;
`ifdef TDM_DEMUX_ERRCNT_EN
    logic [ERRCNT_W-1:0] err_cnt;
`endif

    tdm_demux4 #(.DATA_W(DW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .din         (din),
        .din_valid   (din_valid),
        .frame_sync  (frame_sync),
        .dout        (dout),
        .frame_valid (frame_valid),
        .locked      (locked),
        .sync_err    (sync_err),
        .slot        (slot)
`ifdef TDM_DEMUX_ERRCNT_EN
        ,
        .err_cnt     (err_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       v;
        logic       fs;
        logic       d;
        logic       e_fv;
        logic       e_err;
        logic       e_lock;
        logic [1:0] e_slot;
        logic [3:0] e_dout;
    } vec_t;

    vec_t       vecs [30];
    logic [3:0] sb_q [$];
    int         n_cmp = 0;
    int         n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive at negedge, DUT accepts at posedge, outputs compared at the next negedge.
    task automatic apply(input int idx, input vec_t tv);
        din        = tv.d;
        din_valid  = tv.v;
        frame_sync = tv.fs;
        if (tv.e_fv) sb_q.push_back(tv.e_dout);
        @(posedge clk);
        @(negedge clk);
        chk($sformatf("v%0d.fv", idx), 32'(frame_valid), 32'(tv.e_fv));
        chk($sformatf("v%0d.err", idx), 32'(sync_err), 32'(tv.e_err));
        chk($sformatf("v%0d.lock", idx), 32'(locked), 32'(tv.e_lock));
        chk($sformatf("v%0d.slot", idx), 32'(slot), 32'(tv.e_slot));
        chk($sformatf("v%0d.dout", idx), 32'(dout), 32'(tv.e_dout));
        $display("vec %0d: v=%0b fs=%0b d=%0b -> fv=%0b err=%0b lock=%0b slot=%0d dout=%b",
                 idx, tv.v, tv.fs, tv.d, frame_valid, sync_err, locked, slot, dout);
    endtask

    task automatic beat(input logic v, input logic fs, input logic d);
        din        = d;
        din_valid  = v;
        frame_sync = fs;
        @(posedge clk);
        @(negedge clk);
    endtask

    // Scoreboard: every frame_valid pulse must match the oldest pending frame.
    always @(negedge clk) begin
        if (rst_n && frame_valid) begin
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL sb.unexpected: got frame %b expected none", dout);
            end else begin
                chk("sb.frame", 32'(dout), 32'(sb_q.pop_front()));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //          v   fs  d   fv  err lk  slot  dout
        vecs[0]  = '{1, 1, 0, 0, 0, 1, 2'd1, 4'b0000};
        vecs[1]  = '{1, 0, 1, 0, 0, 1, 2'd2, 4'b0000};
        vecs[2]  = '{1, 0, 0, 0, 0, 1, 2'd3, 4'b0000};
        vecs[3]  = '{1, 0, 1, 1, 0, 1, 2'd0, 4'b1010};
        vecs[4]  = '{1, 1, 1, 0, 0, 1, 2'd1, 4'b1010};
        vecs[5]  = '{1, 0, 1, 0, 0, 1, 2'd2, 4'b1010};
        vecs[6]  = '{1, 0, 0, 0, 0, 1, 2'd3, 4'b1010};
        vecs[7]  = '{1, 0, 0, 1, 0, 1, 2'd0, 4'b0011};
        vecs[8]  = '{1, 1, 0, 0, 0, 1, 2'd1, 4'b0011};
        vecs[9]  = '{1, 0, 0, 0, 0, 1, 2'd2, 4'b0011};
        vecs[10] = '{1, 0, 1, 0, 0, 1, 2'd3, 4'b0011};
        vecs[11] = '{1, 0, 1, 1, 0, 1, 2'd0, 4'b1100};
        vecs[12] = '{1, 1, 1, 0, 0, 1, 2'd1, 4'b1100};
        vecs[13] = '{1, 0, 0, 0, 0, 1, 2'd2, 4'b1100};
        vecs[14] = '{1, 1, 0, 0, 1, 1, 2'd1, 4'b1100};
        vecs[15] = '{1, 0, 1, 0, 0, 1, 2'd2, 4'b1100};
        vecs[16] = '{1, 0, 1, 0, 0, 1, 2'd3, 4'b1100};
        vecs[17] = '{1, 0, 0, 1, 0, 1, 2'd0, 4'b0110};
        vecs[18] = '{1, 0, 1, 0, 1, 0, 2'd0, 4'b0110};
        vecs[19] = '{1, 0, 0, 0, 0, 0, 2'd0, 4'b0110};
        vecs[20] = '{1, 0, 1, 0, 0, 0, 2'd0, 4'b0110};
        vecs[21] = '{1, 1, 1, 0, 0, 1, 2'd1, 4'b0110};
        vecs[22] = '{0, 1, 0, 0, 0, 1, 2'd1, 4'b0110};
        vecs[23] = '{1, 0, 0, 0, 0, 1, 2'd2, 4'b0110};
        vecs[24] = '{0, 0, 1, 0, 0, 1, 2'd2, 4'b0110};
        vecs[25] = '{0, 1, 1, 0, 0, 1, 2'd2, 4'b0110};
        vecs[26] = '{1, 0, 1, 0, 0, 1, 2'd3, 4'b0110};
        vecs[27] = '{0, 0, 0, 0, 0, 1, 2'd3, 4'b0110};
        vecs[28] = '{1, 0, 1, 1, 0, 1, 2'd0, 4'b1101};
        vecs[29] = '{0, 0, 0, 0, 0, 1, 2'd0, 4'b1101};

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst.dout", 32'(dout), 32'd0);
        chk("rst.lock", 32'(locked), 32'd0);
        chk("rst.slot", 32'(slot), 32'd0);
        chk("rst.fv", 32'(frame_valid), 32'd0);
        chk("rst.err", 32'(sync_err), 32'd0);
`ifdef TDM_DEMUX_ERRCNT_EN
        chk("rst.errcnt", 32'(err_cnt), 32'd0);
`endif

        for (int i = 0; i < 30; i++) begin
            apply(i, vecs[i]);
        end
`ifdef TDM_DEMUX_ERRCNT_EN
        chk("tbl.errcnt", 32'(err_cnt), 32'd2);
`endif

        // Reset asserted asynchronously mid-frame clears outputs before any edge.
        beat(1, 1, 1);
        beat(1, 0, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst.dout", 32'(dout), 32'd0);
        chk("mid_rst.lock", 32'(locked), 32'd0);
        chk("mid_rst.slot", 32'(slot), 32'd0);
        $display("mid-frame reset: dout=%b lock=%0b slot=%0d", dout, locked, slot);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Partial frame must not leak into the next one.
        sb_q.push_back(4'b0100);
        beat(1, 1, 0);
        beat(1, 0, 0);
        beat(1, 0, 1);
        beat(1, 0, 0);
        chk("post_rst.fv", 32'(frame_valid), 32'd1);
        chk("post_rst.dout", 32'(dout), 32'b0100);
        $display("post-reset frame: fv=%0b dout=%b", frame_valid, dout);

`ifdef TDM_DEMUX_ERRCNT_EN
        chk("pre_sat.errcnt", 32'(err_cnt), 32'd0);
        beat(1, 1, 0);
        for (int i = 0; i < 300; i++) begin
            beat(1, 1, 0);
        end
        chk("sat.errcnt", 32'(err_cnt), 32'hFF);
        $display("saturation: err_cnt=%0h", err_cnt);
`endif

        beat(0, 0, 0);
        chk("sb.empty", 32'(sb_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
